// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the motion controller state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   CNT_W, H_ACTIVE, V_ACTIVE  raster geometry used by the sprite logic
//   motion_state_t             per-frame update sequencer states
package vga_pkg;

  localparam int CNT_W    = 10;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    CALC   = 2'd2,
    COMMIT = 2'd3
  } motion_state_t;

endpackage

// File: rtl/vga_frame_tick.sv
// Detects the start of vertical blanking and emits a registered one-cycle frame tick.
// Latency: tick_o rises one clk after the counters reach (h=0, v=V_ACTIVE).
// Backpressure: none; free-running, follows the raster counters.
//
// Ports:
//   clk, rst_n     pixel clock, async active-low reset
//   h_cnt_i        horizontal counter
//   v_cnt_i        vertical counter
//   tick_next_o    combinational: tick_o will be high next cycle
//   tick_o         registered one-cycle frame tick
module vga_frame_tick #(
  parameter int CNT_W    = 10,
  parameter int V_ACTIVE = 480
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] h_cnt_i,
  input  logic [CNT_W-1:0] v_cnt_i,
  output logic             tick_next_o,
  output logic             tick_o
);

  localparam logic [CNT_W-1:0] V_TICK = CNT_W'(V_ACTIVE);

  logic match;
  logic match_q;
  logic tick_q;

  assign match = (h_cnt_i == '0) && (v_cnt_i == V_TICK);

  // Only the first cycle of a match counts, so counters that stall on the
  // tick point still produce a single pulse instead of a stuck-high tick.
  assign tick_next_o = match & ~match_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      match_q <= match;
      tick_q  <= tick_next_o;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Owns the sprite position; applies latched button moves or autonomous bounce once per frame in vblank.
// Latency: posX/posY/hit_edge update 2 clk after the frame_tick cycle.
// Backpressure: none; button edges are held sticky until the next commit consumes them.
//
// Ports:
//   clk, reset                         pixel clock, async active-low reset
//   hCounter, vCounter                 raster counters from the sync generator
//   btn_up/down/left/right             level move requests, synchronous to clk
//   auto_en                            1 = bounce autonomously on axes without a manual request
//   posX, posY                         registered sprite position
//   frame_tick                         one-cycle pulse at the start of vertical blanking
//   hit_edge                           one-cycle pulse when a commit clamped on either axis
module sprite_motion_ctrl #(
  parameter int CNT_W    = vga_pkg::CNT_W,
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 32,
  parameter int STEP     = 4,
  parameter int X_INIT   = 200,
  parameter int Y_INIT   = 300
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] hCounter,
  input  logic [CNT_W-1:0] vCounter,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             auto_en,
  output logic [CNT_W-1:0] posX,
  output logic [CNT_W-1:0] posY,
  output logic             frame_tick,
  output logic             hit_edge
);

  import vga_pkg::*;

  // Signed arithmetic is one bit wider than the position so that a step
  // below zero is visible as a negative value rather than wrapping.
  localparam logic signed [CNT_W:0] STEP_S = (CNT_W+1)'(STEP);
  localparam logic signed [CNT_W:0] X_MAX  = (CNT_W+1)'(H_ACTIVE - SPRITE_W);
  localparam logic signed [CNT_W:0] Y_MAX  = (CNT_W+1)'(V_ACTIVE - SPRITE_H);

  // Result word per axis: {flip_dir, hit, new_pos}
  localparam int RES_W = CNT_W + 2;

  // Request bit positions in the pending vector
  localparam int B_UP    = 3;
  localparam int B_DOWN  = 2;
  localparam int B_LEFT  = 1;
  localparam int B_RIGHT = 0;

  // ---------------------------------------------------------------------------
  // Per-axis next position and clamp.
  //   req_neg/req_pos : latched manual requests toward smaller/larger values
  //   auto_on         : autonomous motion enabled (sampled in CALC)
  //   dir_neg         : current autonomous direction, 1 = toward zero
  // A manual request (including both opposite bits, which cancel) owns the
  // axis for this frame, so only an auto-driven clamp reverses direction.
  // ---------------------------------------------------------------------------
  function automatic logic [RES_W-1:0] axis_next(
    input logic [CNT_W-1:0]        pos,
    input logic                    req_neg,
    input logic                    req_pos,
    input logic                    auto_on,
    input logic                    dir_neg,
    input logic signed [CNT_W:0]   max_v
  );
    logic signed [CNT_W:0] delta;
    logic signed [CNT_W:0] sum;
    logic                  manual;
    logic                  hit;
    logic                  flip;
    logic [CNT_W-1:0]      res;

    manual = req_neg | req_pos;
    delta  = '0;
    if (manual) begin
      if (req_neg && !req_pos) begin
        delta = -STEP_S;
      end else if (req_pos && !req_neg) begin
        delta = STEP_S;
      end
    end else if (auto_on) begin
      delta = dir_neg ? -STEP_S : STEP_S;
    end

    sum = $signed({1'b0, pos}) + delta;
    hit = 1'b0;
    res = sum[CNT_W-1:0];
    if (sum < 0) begin
      res = '0;
      hit = 1'b1;
    end else if (sum > max_v) begin
      res = max_v[CNT_W-1:0];
      hit = 1'b1;
    end

    flip = hit & ~manual & auto_on;
    return {flip, hit, res};
  endfunction

  // ---------------------------------------------------------------------------
  // Frame tick
  // ---------------------------------------------------------------------------
  logic tick_next;

  vga_frame_tick #(
    .CNT_W    (CNT_W),
    .V_ACTIVE (V_ACTIVE)
  ) u_frame_tick (
    .clk         (clk),
    .rst_n       (reset),
    .h_cnt_i     (hCounter),
    .v_cnt_i     (vCounter),
    .tick_next_o (tick_next),
    .tick_o      (frame_tick)
  );

  // ---------------------------------------------------------------------------
  // Sequencer. It advances on tick_next so that CALC is the frame_tick cycle
  // and COMMIT the one after; the new position is then visible two cycles
  // after frame_tick, well inside vertical blanking.
  // ---------------------------------------------------------------------------
  motion_state_t state_q, state_d;
  logic          calc_en;
  logic          commit_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      // The first tick after reset only synchronises to the raster.
      IDLE:    if (tick_next) state_d = WAIT;
      WAIT:    if (tick_next) state_d = CALC;
      CALC:    state_d = COMMIT;
      COMMIT:  state_d = WAIT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    calc_en   = (state_q == CALC);
    commit_en = (state_q == COMMIT);
  end

  // ---------------------------------------------------------------------------
  // Request latch. Only the bits that CALC actually consumed are cleared at
  // COMMIT, so an edge arriving during CALC or COMMIT survives to next frame.
  // ---------------------------------------------------------------------------
  logic [3:0] btn_now;
  logic [3:0] btn_q;
  logic [3:0] pend_q, pend_d;
  logic [3:0] used_q;

  assign btn_now = {btn_up, btn_down, btn_left, btn_right};

  always_comb begin
    pend_d = pend_q;
    if (commit_en) begin
      pend_d = pend_d & ~used_q;
    end
    pend_d = pend_d | (btn_now & ~btn_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_q  <= '0;
      pend_q <= '0;
    end else begin
      btn_q  <= btn_now;
      pend_q <= pend_d;
    end
  end

  // ---------------------------------------------------------------------------
  // CALC: evaluate both axes and hold the results for COMMIT.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] pos_x_q, pos_y_q;
  logic             dir_x_q, dir_y_q;   // 1 = moving toward zero
  logic [RES_W-1:0] res_x_d, res_y_d;
  logic [RES_W-1:0] res_x_q, res_y_q;
  logic             hit_q;

  always_comb begin
    res_x_d = axis_next(pos_x_q, pend_q[B_LEFT], pend_q[B_RIGHT], auto_en, dir_x_q, X_MAX);
    res_y_d = axis_next(pos_y_q, pend_q[B_UP],   pend_q[B_DOWN],  auto_en, dir_y_q, Y_MAX);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_x_q <= '0;
      res_y_q <= '0;
      used_q  <= '0;
    end else if (calc_en) begin
      res_x_q <= res_x_d;
      res_y_q <= res_y_d;
      used_q  <= pend_q;
    end
  end

  // ---------------------------------------------------------------------------
  // COMMIT: publish position, pulse hit_edge, reverse bounced axes.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_x_q <= CNT_W'(X_INIT);
      pos_y_q <= CNT_W'(Y_INIT);
      dir_x_q <= 1'b0;
      dir_y_q <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      hit_q <= commit_en & (res_x_q[CNT_W] | res_y_q[CNT_W]);
      if (commit_en) begin
        pos_x_q <= res_x_q[CNT_W-1:0];
        pos_y_q <= res_y_q[CNT_W-1:0];
        dir_x_q <= dir_x_q ^ res_x_q[CNT_W+1];
        dir_y_q <= dir_y_q ^ res_y_q[CNT_W+1];
      end
    end
  end

  assign posX     = pos_x_q;
  assign posY     = pos_y_q;
  assign hit_edge = hit_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Self-checking bench for sprite_motion_ctrl: drives a compressed raster,
// button/auto stimulus, and checks every frame against a behavioural model.
module tb_sprite_motion_ctrl;

  localparam int CNT_W    = 10;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int STEP     = 4;
  localparam int X_MAX    = H_ACTIVE - 32;
  localparam int Y_MAX    = V_ACTIVE - 32;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [CNT_W-1:0] hCounter = '0;
  logic [CNT_W-1:0] vCounter = '0;
  logic             btn_up, btn_down, btn_left, btn_right;
  logic             auto_en = 1'b0;
  logic [CNT_W-1:0] posX, posY;
  logic             frame_tick, hit_edge;

  logic [3:0] btn_cur = 4'b0;   // {up, down, left, right}
  assign {btn_up, btn_down, btn_left, btn_right} = btn_cur;

  always #5 clk = ~clk;

  sprite_motion_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .hCounter   (hCounter),
    .vCounter   (vCounter),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .auto_en    (auto_en),
    .posX       (posX),
    .posY       (posY),
    .frame_tick (frame_tick),
    .hit_edge   (hit_edge)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  int         mx, my;       // position
  int         dx, dy;       // auto direction, +1 / -1
  logic [3:0] pend;         // requests seen since last applied frame
  bit         started;      // first tick after reset has passed

  task automatic model_reset();
    mx = 200; my = 300; dx = 1; dy = 1; pend = 4'b0; started = 0;
  endtask

  // One axis for one frame, straight from the motion rules.
  task automatic model_axis(input int p, input int d, input bit neg, input bit posr,
                            input bit au, input int maxv,
                            output int np, output int nd, output bit hit);
    int  delta;
    bit  manual;
    manual = neg | posr;
    delta  = 0;
    if (manual) delta = (posr ? STEP : 0) - (neg ? STEP : 0);
    else if (au) delta = d * STEP;
    np  = p + delta;
    nd  = d;
    hit = 0;
    if (np < 0) begin np = 0; hit = 1; end
    else if (np > maxv) begin np = maxv; hit = 1; end
    if (hit && !manual && au) nd = -d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Change buttons just after an edge; any newly pressed button is a request.
  task automatic set_btns(input logic [3:0] b);
    pend    = pend | (b & ~btn_cur);
    btn_cur = b;
  endtask

  // Visible part of a frame: n cycles, optionally random buttons and auto_en.
  task automatic active(input int n, input bit rnd);
    vCounter = '0;
    for (int i = 0; i < n; i++) begin
      hCounter = i[CNT_W-1:0] + 10'd1;
      if (rnd) begin
        set_btns(($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0);
        if ($urandom_range(0, 2) == 0) auto_en = 1'($urandom);
      end
      step();
    end
  endtask

  // Vertical blanking with one tick; checks exact commit timing.
  task automatic run_frame(input string tag);
    int ex, ey, ndx, ndy;
    bit hx, hy, eh;
    vCounter = CNT_W'(V_ACTIVE);
    hCounter = 10'd7;
    step();
    hCounter = '0;
    if (!started) begin
      started = 1; ex = mx; ey = my; eh = 0; ndx = dx; ndy = dy;
    end else begin
      model_axis(mx, dx, pend[1], pend[0], auto_en, X_MAX, ex, ndx, hx);
      model_axis(my, dy, pend[3], pend[2], auto_en, Y_MAX, ey, ndy, hy);
      eh   = hx | hy;
      pend = 4'b0;
    end
    step();   // frame_tick cycle
    hCounter = 10'd1;
    n_tests++;
    if (frame_tick !== 1'b1 || posX !== mx || posY !== my || hit_edge !== 1'b0) begin
      n_fail++;
      $display("FAIL %s tick_cycle: tick=%0d pos=(%0d,%0d) hit=%0d, want tick=1 pos=(%0d,%0d) hit=0",
               tag, frame_tick, posX, posY, hit_edge, mx, my);
    end
    step();   // tick+1
    hCounter = 10'd2;
    n_tests++;
    if (frame_tick !== 1'b0 || posX !== mx || posY !== my || hit_edge !== 1'b0) begin
      n_fail++;
      $display("FAIL %s tick_plus1: tick=%0d pos=(%0d,%0d) hit=%0d, want tick=0 pos=(%0d,%0d) hit=0",
               tag, frame_tick, posX, posY, hit_edge, mx, my);
    end
    step();   // tick+2: new position visible
    n_tests++;
    if (posX !== ex || posY !== ey || hit_edge !== eh) begin
      n_fail++;
      $display("FAIL %s commit: pos=(%0d,%0d) hit=%0d, want pos=(%0d,%0d) hit=%0d",
               tag, posX, posY, hit_edge, ex, ey, eh);
    end
    step();
    n_tests++;
    if (hit_edge !== 1'b0 || posX !== ex || posY !== ey) begin
      n_fail++;
      $display("FAIL %s after_commit: hit=%0d pos=(%0d,%0d), want hit=0 pos=(%0d,%0d)",
               tag, hit_edge, posX, posY, ex, ey);
    end
    mx = ex; my = ey; dx = ndx; dy = ndy;
  endtask

  task automatic press(input logic [3:0] b);
    set_btns(b);
    step();
    set_btns(4'b0);
    step();
  endtask

  task automatic check_reset_vals(input string tag);
    n_tests++;
    if (posX !== 10'd200 || posY !== 10'd300 || frame_tick !== 1'b0 || hit_edge !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: pos=(%0d,%0d) tick=%0d hit=%0d, want pos=(200,300) tick=0 hit=0",
               tag, posX, posY, frame_tick, hit_edge);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; btn_cur = 4'b0; auto_en = 1'b0;
    step(); step();
    check_reset_vals("reset_state");
    reset = 1'b1;
    model_reset();
    active(5, 0);
    run_frame("idle_frame");
  endtask

  task automatic test_auto();
    auto_en = 1'b1;
    active(4, 0);
    run_frame("auto_1");
    n_tests++;
    if (posX !== 10'd204 || posY !== 10'd304) begin
      n_fail++;
      $display("FAIL auto_first: pos=(%0d,%0d), want (204,304)", posX, posY);
    end
    active(4, 0);
    run_frame("auto_2");
    n_tests++;
    if (posX !== 10'd208 || posY !== 10'd308) begin
      n_fail++;
      $display("FAIL auto_second: pos=(%0d,%0d), want (208,308)", posX, posY);
    end
  endtask

  task automatic test_manual();
    auto_en = 1'b0;
    active(2, 0);
    press(4'b0010); press(4'b0010); press(4'b0010);
    run_frame("left_x3");
    active(2, 0);
    press(4'b0011);
    run_frame("left_right");
    // Held across two frames: only one request.
    active(2, 0);
    set_btns(4'b0010);
    active(2, 0);
    run_frame("held_1");
    active(2, 0);
    run_frame("held_2");
    set_btns(4'b0000);
    active(2, 0);
    press(4'b0100);
    run_frame("down");
  endtask

  task automatic test_auto_edge();
    auto_en = 1'b1;
    for (int f = 0; f < 110; f++) begin
      active(3, 0);
      run_frame("auto_edge");
    end
  endtask

  task automatic test_underflow();
    auto_en = 1'b0;
    for (int f = 0; f < 150 && my > 0; f++) begin
      active(2, 0);
      press(4'b1000);
      run_frame("up_walk");
    end
    active(2, 0);
    press(4'b1000);
    run_frame("up_at_zero");
    active(2, 0);
    run_frame("zero_idle");
    n_tests++;
    if (posY !== 10'd0) begin
      n_fail++;
      $display("FAIL underflow_floor: posY=%0d, want 0", posY);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 80; f++) begin
      active($urandom_range(2, 8), 1);
      run_frame("random");
    end
    set_btns(4'b0);
    step();
  endtask

  task automatic test_missing_counters();
    int bad;
    bad = 0;
    auto_en = 1'b1;
    vCounter = CNT_W'(V_ACTIVE);
    hCounter = 10'd3;
    for (int i = 0; i < 300; i++) begin
      step();
      if (frame_tick !== 1'b0 || posX !== mx || posY !== my || hit_edge !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL missing_counters: %0d bad cycles, want 0 (pos held at (%0d,%0d))", bad, mx, my);
    end
  endtask

  task automatic test_reset_mid_calc();
    auto_en = 1'b0;
    active(2, 0);
    press(4'b0100);
    run_frame("pre_down");
    active(2, 0);
    press(4'b0100);
    vCounter = CNT_W'(V_ACTIVE);
    hCounter = 10'd7;
    step();
    hCounter = '0;
    step();   // DUT is now in CALC
    reset = 1'b0;
    #1;
    check_reset_vals("reset_in_calc");
    step();
    check_reset_vals("reset_held");
    reset = 1'b1;
    model_reset();
    active(3, 0);
    run_frame("post_reset_idle");
    active(3, 0);
    run_frame("post_reset_pend_cleared");
    n_tests++;
    if (posY !== 10'd300) begin
      n_fail++;
      $display("FAIL reset_pending: posY=%0d, want 300", posY);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_auto();
    test_manual();
    test_auto_edge();
    test_underflow();
    test_random();
    test_missing_counters();
    test_reset_mid_calc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
